fft_reorder_seq: RTL

//  Frame sequencer for the FFT input buffer. Accepts one frame of N=2**ADDR_BITS

---
 rtl/fft_reorder_seq_pkg.sv | 15 +
 rtl/fft_reorder_seq_if.sv | 35 +++
 rtl/fft_reorder_seq_addr_bitrev.sv | 11 +
 rtl/fft_reorder_seq.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fft_reorder_seq_pkg.sv
// Shared types for the FFT input-frame sequencer: FSM state encoding and frame-length helper.
package fft_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    function automatic int frame_len(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/fft_reorder_seq_if.sv
// Sequencer bus: sample input stream, RAM ports, FFT core handshake and output stream.
// master = sequencer side, slave = source/RAM/core/sink side.
interface fft_reorder_seq_if #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_W    = 16
);
    logic                 en;
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_W-1:0]    s_data;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 mem_re;
    logic [ADDR_BITS-1:0] mem_raddr;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 fft_start;
    logic                 fft_done;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_W-1:0]    m_data;
    logic                 frame_done;

    modport master (
        input  en, s_valid, s_data, mem_rdata, fft_done, m_ready,
        output s_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
               fft_start, m_valid, m_data, frame_done
    );

    modport slave (
        output en, s_valid, s_data, mem_rdata, fft_done, m_ready,
        input  s_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
               fft_start, m_valid, m_data, frame_done
    );
endinterface

// File: rtl/fft_reorder_seq_addr_bitrev.sv
// Full bit reversal of an address: out[i] = in[ADDR_BITS-1-i]. Purely combinational.
module addr_bitrev #(
    parameter int ADDR_BITS = 4
) (
    input  logic [ADDR_BITS-1:0] addr_i,
    output logic [ADDR_BITS-1:0] addr_o
);
    for (genvar i = 0; i < ADDR_BITS; i++) begin : g_rev
        assign addr_o[i] = addr_i[ADDR_BITS-1-i];
    end
endmodule

// File: rtl/fft_reorder_seq.sv
// FFT frame sequencer: bit-reversed load into sample RAM, core start/wait, natural-order drain.
// Optional FFT_FRAME_CNT_EN adds a 16-bit wrapping count of completed frames on frame_cnt.
module fft_reorder_seq
    import fft_seq_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int DATA_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    fft_reorder_seq_if.master   bus
`ifdef FFT_FRAME_CNT_EN
    ,
    output logic [15:0]         frame_cnt
`endif
);
    localparam logic [ADDR_BITS:0] N_CNT = (ADDR_BITS+1)'(frame_len(ADDR_BITS));

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] wcnt_q, wcnt_d;
    logic [ADDR_BITS:0]   icnt_q, icnt_d;
    logic [ADDR_BITS-1:0] ocnt_q, ocnt_d;
    logic                 pend_q, pend_d;
    logic                 start_q, start_d;

    logic                 s_ready, we, re, m_valid, frame_done, issue;
    logic [ADDR_BITS-1:0] waddr, raddr, waddr_rev;
    logic [DATA_W-1:0]    wdata, m_data;

    addr_bitrev #(.ADDR_BITS(ADDR_BITS)) u_bitrev (
        .addr_i (wcnt_q),
        .addr_o (waddr_rev)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            icnt_q  <= '0;
            ocnt_q  <= '0;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            icnt_q  <= icnt_d;
            ocnt_q  <= ocnt_d;
            pend_q  <= pend_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        icnt_d     = icnt_q;
        ocnt_d     = ocnt_q;
        pend_d     = pend_q;
        start_d    = 1'b0;
        s_ready    = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        re         = 1'b0;
        raddr      = '0;
        m_valid    = 1'b0;
        m_data     = '0;
        frame_done = 1'b0;
        issue      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) state_d = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (bus.s_valid) begin
                    we     = 1'b1;
                    waddr  = waddr_rev;
                    wdata  = bus.s_data;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == '1) begin
                        wcnt_d  = '0;
                        start_d = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.fft_done) state_d = DRAIN;
            end
            DRAIN: begin
                // One read in flight at most; a new read may be issued in the cycle the
                // current beat is accepted, so rdata stays put while the sink stalls.
                issue   = (icnt_q < N_CNT) && (!pend_q || bus.m_ready);
                re      = issue;
                raddr   = icnt_q[ADDR_BITS-1:0];
                m_valid = pend_q;
                m_data  = bus.mem_rdata;
                if (issue) icnt_d = icnt_q + 1'b1;
                pend_d = issue ? 1'b1 : (bus.m_ready ? 1'b0 : pend_q);
                if (pend_q && bus.m_ready) begin
                    ocnt_d = ocnt_q + 1'b1;
                    if (ocnt_q == '1) begin
                        frame_done = 1'b1;
                        icnt_d     = '0;
                        ocnt_d     = '0;
                        pend_d     = 1'b0;
                        state_d    = bus.en ? LOAD : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_ready    = s_ready;
    assign bus.mem_we     = we;
    assign bus.mem_waddr  = waddr;
    assign bus.mem_wdata  = wdata;
    assign bus.mem_re     = re;
    assign bus.mem_raddr  = raddr;
    assign bus.fft_start  = start_q;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = m_data;
    assign bus.frame_done = frame_done;

`ifdef FFT_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             frame_cnt_q <= '0;
        else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt = frame_cnt_q;
`endif
endmodule
